// File: rtl/alarm_time_set.sv
// alarm_time_set
//   Captures the alarm time from the slide switches under pushbutton control
//   and drives committed BCD hour/minute buses to the alarm comparator.
//   Contains the key synchronizer/debouncer, a set-mode FSM, BCD range
//   validation and an atomic hour/minute commit.
//
// Ports:
//   CLOCK_50   in   system clock, all state on rising edge
//   KEY0       in   asynchronous active-low reset
//   SET_KEY_N  in   raw active-low pushbutton (asynchronous)
//   SET_EN     in   1 = alarm editing permitted
//   SET_IN     in   [7:4] BCD tens, [3:0] BCD ones from switches
//   A_HOUR     out  committed alarm hour, BCD 00-23
//   A_MIN      out  committed alarm minute, BCD 00-59
//   MODE       out  00 IDLE, 01 SET_HOUR, 10 SET_MIN
//   ERR        out  1-cycle pulse: press rejected, out-of-range BCD
//   DONE       out  1-cycle pulse: new alarm committed
module alarm_time_set #(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter logic [7:0] RESET_HOUR      = 8'h06,
    parameter logic [7:0] RESET_MIN       = 8'h30
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic       SET_KEY_N,
    input  logic       SET_EN,
    input  logic [7:0] SET_IN,
    output logic [7:0] A_HOUR,
    output logic [7:0] A_MIN,
    output logic [1:0] MODE,
    output logic       ERR,
    output logic       DONE
);

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_SET_HOUR = 2'b01;
    localparam logic [1:0] ST_SET_MIN  = 2'b10;

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Key conditioning: 2-flop synchronizer, then a counter that accepts
    // a level change only after it has held for DEBOUNCE_CYCLES cycles.
    // ------------------------------------------------------------------
    logic             key_meta;
    logic             key_sync;
    logic             key_stable;
    logic             key_stable_d;
    logic [CNT_W-1:0] db_cnt;
    logic             press;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= SET_KEY_N;
            key_sync <= key_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            key_stable <= 1'b1;
            db_cnt     <= '0;
        end else if (key_sync == key_stable) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_MAX) begin
            key_stable <= key_sync;
            db_cnt     <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) key_stable_d <= 1'b1;
        else       key_stable_d <= key_stable;
    end

    // One strobe per accepted 1->0 transition; release produces nothing.
    assign press = key_stable_d & ~key_stable;

    // ------------------------------------------------------------------
    // BCD range checks on the switch value
    // ------------------------------------------------------------------
    logic [3:0] in_tens;
    logic [3:0] in_ones;
    logic       hour_ok;
    logic       min_ok;

    assign in_tens = SET_IN[7:4];
    assign in_ones = SET_IN[3:0];
    assign hour_ok = (in_ones <= 4'd9) &&
                     ((in_tens < 4'd2) || ((in_tens == 4'd2) && (in_ones <= 4'd3)));
    assign min_ok  = (in_tens <= 4'd5) && (in_ones <= 4'd9);

    // ------------------------------------------------------------------
    // Set-mode FSM. Dropping SET_EN always wins over a coincident press.
    // The hour is held in pend_hour so A_HOUR/A_MIN move together.
    // ------------------------------------------------------------------
    logic [1:0] state;
    logic [7:0] pend_hour;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state     <= ST_IDLE;
            pend_hour <= 8'h00;
            A_HOUR    <= RESET_HOUR;
            A_MIN     <= RESET_MIN;
            ERR       <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            ERR  <= 1'b0;
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (press && SET_EN) state <= ST_SET_HOUR;
                end
                ST_SET_HOUR: begin
                    if (!SET_EN) begin
                        state <= ST_IDLE;
                    end else if (press) begin
                        if (hour_ok) begin
                            pend_hour <= SET_IN;
                            state     <= ST_SET_MIN;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                ST_SET_MIN: begin
                    if (!SET_EN) begin
                        state <= ST_IDLE;
                    end else if (press) begin
                        if (min_ok) begin
                            A_HOUR <= pend_hour;
                            A_MIN  <= SET_IN;
                            DONE   <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign MODE = state;

endmodule
